// File: rtl/image_mem_pkg.sv
// -----------------------------------------------------------------------------
// image_mem_pkg
//   Shared definitions for the image memory reader: default geometry of the
//   image memory, the scan FSM state type and a small address helper.
//
//   Contents
//     DEF_ADDR_W      default word-address width of the image memory
//     DEF_DATA_W      default pixel width
//     DEF_MEM_WORDS   default image memory depth in words
//     DEF_FIFO_DEPTH  default number of output buffer entries
//     state_t         scan FSM states (IDLE, RUN, DRAIN)
//     next_word()     address increment that wraps at the end of the memory
// -----------------------------------------------------------------------------
package image_mem_pkg;

  localparam int DEF_ADDR_W     = 17;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_MEM_WORDS  = 81920;
  localparam int DEF_FIFO_DEPTH = 4;

  // IDLE  : waiting for a start request
  // RUN   : words remain to be requested from the memory
  // DRAIN : every read is issued, waiting for the buffer to empty
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // The memory depth is not a power of two, so the address has to wrap
  // explicitly from the last word back to word 0.
  function automatic int unsigned next_word(input int unsigned addr,
                                            input int unsigned words);
    if (addr + 1 >= words) begin
      return 0;
    end
    return addr + 1;
  endfunction

endpackage

// File: rtl/image_mem_fifo.sv
// -----------------------------------------------------------------------------
// image_mem_fifo
//   Small synchronous FIFO buffering pixels between the image memory and the
//   pixel stream. Reads are first-word-fall-through: the head entry is always
//   visible on pop_data, and pop_data reads as zero while the FIFO is empty.
//   A flush empties the FIFO and overrides any push or pop in the same cycle.
//
//   Parameters
//     WIDTH  entry width
//     DEPTH  number of entries (power of two, >= 2)
//
//   Ports
//     clk        single clock
//     reset_n    asynchronous active-low reset
//     flush      synchronous clear of all entries
//     push       write push_data (ignored when full without a pop)
//     push_data  entry to write
//     pop        remove the head entry (ignored when empty)
//     pop_data   head entry, zero when empty
//     count      number of stored entries (0..DEPTH)
//     empty      count == 0
// -----------------------------------------------------------------------------
module image_mem_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle, because the freed slot is the one being written.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Gating with !empty keeps pix_data at zero whenever nothing is valid,
  // including during reset, without having to reset the storage array.
  assign pop_data = empty ? '0 : storage[rd_ptr];

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the separate
  // count distinguishes full from empty when the pointers are equal.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/image_mem_reader.sv
// -----------------------------------------------------------------------------
// image_mem_reader
//   Scans a contiguous run of words out of an image memory over an Avalon-MM
//   read-only master and streams them out as pixels with valid/ready flow
//   control. The memory has a fixed read latency of one cycle. Reads are
//   throttled so the output buffer can always absorb every read in flight,
//   which means a stalled consumer never loses data.
//
//   Optional feature
//     IMAGE_MEM_READER_CKSUM_EN  when defined, cksum holds the 16-bit sum of
//                                all pixels transferred since the last
//                                accepted start; otherwise cksum is zero and
//                                no accumulator is built.
//
//   Parameters
//     ADDR_W      word-address width of the image memory
//     DATA_W      pixel width
//     MEM_WORDS   image memory depth; addresses wrap from MEM_WORDS-1 to 0
//     FIFO_DEPTH  output buffer entries (power of two, >= 2)
//
//   Ports
//     clk, reset_n    clock and asynchronous active-low reset
//     start           one-cycle request to begin a scan (only honoured in IDLE)
//     abort           synchronous cancel; wins over start
//     base_addr       first word of the scan
//     length          number of words in the scan
//     m_address       memory word address
//     m_chipselect    one read request in this cycle
//     m_write         always 0 (read-only master)
//     m_clken         always 1
//     m_writedata     always 0
//     m_readdata      read data, valid the cycle after m_chipselect
//     pix_data        pixel stream data
//     pix_valid       pixel stream valid (buffer not empty)
//     pix_ready       pixel stream ready
//     busy            a scan is in progress
//     done            one-cycle pulse when a scan completes normally
//     cksum           pixel checksum (see optional feature)
// -----------------------------------------------------------------------------
module image_mem_reader #(
  parameter int ADDR_W     = image_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W     = image_mem_pkg::DEF_DATA_W,
  parameter int MEM_WORDS  = image_mem_pkg::DEF_MEM_WORDS,
  parameter int FIFO_DEPTH = image_mem_pkg::DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic              m_clken,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       cksum
);

  import image_mem_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [ADDR_W-1:0] remaining;
  logic              inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [CNT_W:0]    occupancy;
  logic              read_issue;
  logic              start_accept;
  logic              pix_xfer;

  assign m_write     = 1'b0;
  assign m_clken     = 1'b1;
  assign m_writedata = '0;

  assign busy         = (state != IDLE);
  assign start_accept = (state == IDLE) && start && !abort;
  assign pix_valid    = !fifo_empty;
  assign pix_xfer     = pix_valid && pix_ready;

  // Entries already buffered plus the read still on its way back; a new read
  // is only allowed while this leaves room for its data.
  assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign read_issue = (state == RUN) && (remaining != '0)
                      && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign m_chipselect = read_issue;

  // The data for last cycle's read arrives now and goes straight into the
  // buffer; an abort flushes the buffer and drops that word.
  image_mem_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (abort),
    .push      (inflight),
    .push_data (m_readdata),
    .pop       (pix_xfer),
    .pop_data  (pix_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Scan control. inflight remembers that a read was issued last cycle so the
  // returning word is captured. RUN always spends one cycle with remaining at
  // zero before DRAIN, which gives a zero-length scan its two busy cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      m_address <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= read_issue;
      if (abort) begin
        state    <= IDLE;
        inflight <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= RUN;
              m_address <= base_addr;
              remaining <= length;
            end
          end
          RUN: begin
            if (read_issue) begin
              m_address <= ADDR_W'(next_word(32'(m_address), MEM_WORDS));
              remaining <= remaining - ADDR_W'(1);
            end
            if (remaining == '0) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (!inflight && fifo_empty) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef IMAGE_MEM_READER_CKSUM_EN
  logic [15:0] cksum_acc;

  // Running sum of delivered pixels, restarted by each accepted start. The
  // buffer is always empty in IDLE, so a clear never coincides with a pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cksum_acc <= '0;
    end else if (start_accept) begin
      cksum_acc <= '0;
    end else if (pix_xfer) begin
      cksum_acc <= cksum_acc + 16'(pix_data);
    end
  end

  assign cksum = cksum_acc;
`else
  // start_accept only feeds the checksum clear; keep it referenced here.
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
  assign cksum = 16'd0;
`endif

endmodule

// File: tb/tb_image_mem_reader.sv
// -----------------------------------------------------------------------------
// tb_image_mem_reader
//   Self-checking bench for image_mem_reader. A behavioural memory answers
//   reads one cycle late; monitors log issued addresses, delivered pixels and
//   done pulses. Each scan is compared against the expected word sequence
//   (base+i) mod MEM_WORDS taken straight from the memory contents.
//   Honours IMAGE_MEM_READER_CKSUM_EN for the expected checksum.
// -----------------------------------------------------------------------------
module tb_image_mem_reader;

  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 8;
  localparam int MEM_WORDS  = 81920;
  localparam int FIFO_DEPTH = 4;
  localparam int BUDGET     = 2000;

`ifdef IMAGE_MEM_READER_CKSUM_EN
  localparam bit CKSUM_EN = 1'b1;
`else
  localparam bit CKSUM_EN = 1'b0;
`endif

  logic              clk       = 1'b0;
  logic              reset_n   = 1'b0;
  logic              start     = 1'b0;
  logic              abort     = 1'b0;
  logic              pix_ready = 1'b1;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] length    = '0;
  logic [DATA_W-1:0] m_readdata = '0;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write;
  logic              m_clken;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              busy;
  logic              done;
  logic [15:0]       cksum;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  int addr_log[$];
  int pix_log[$];
  int done_cnt = 0;
  int checks   = 0;
  int errors   = 0;

  always #5 clk = ~clk;

  image_mem_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_WORDS  (MEM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .base_addr    (base_addr),
    .length       (length),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_clken      (m_clken),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .busy         (busy),
    .done         (done),
    .cksum        (cksum)
  );

  // Memory with one cycle of read latency, plus the address/pixel/done logs.
  always @(posedge clk) begin
    if (m_chipselect) begin
      m_readdata <= mem[m_address];
      addr_log.push_back(int'(m_address));
    end
    if (pix_valid && pix_ready) begin
      pix_log.push_back(int'(pix_data));
    end
    if (done) begin
      done_cnt++;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int base, input int len);
    pix_log.delete();
    addr_log.delete();
    done_cnt  = 0;
    base_addr = ADDR_W'(base);
    length    = ADDR_W'(len);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready);
    int cyc;
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
    end
    check_output("done_seen", done, 1);
    pix_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_scan(input string name, input int base, input int len);
    int sum;
    int a;
    sum = 0;
    check_output({name, "_addr_count"}, addr_log.size(), len);
    check_output({name, "_pix_count"}, pix_log.size(), len);
    for (int i = 0; i < len; i++) begin
      a   = (base + i) % MEM_WORDS;
      sum = (sum + int'(mem[a])) % 65536;
      if (i < addr_log.size())
        check_output($sformatf("%s_addr[%0d]", name, i), addr_log[i], a);
      if (i < pix_log.size())
        check_output($sformatf("%s_pix[%0d]", name, i), pix_log[i], int'(mem[a]));
    end
    check_output({name, "_done_once"}, done_cnt, 1);
    check_output({name, "_cksum"}, cksum, CKSUM_EN ? sum : 0);
    check_output({name, "_idle_after"}, busy, 0);
  endtask

  task automatic check_reset_values(input string name);
    check_output({name, "_cs"}, m_chipselect, 0);
    check_output({name, "_addr"}, m_address, 0);
    check_output({name, "_valid"}, pix_valid, 0);
    check_output({name, "_pix"}, pix_data, 0);
    check_output({name, "_busy"}, busy, 0);
    check_output({name, "_done"}, done, 0);
    check_output({name, "_cksum"}, cksum, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int b;
    int l;
    int reads;
    int cyc;
    int stall_bad;

    for (int i = 0; i < MEM_WORDS; i++) mem[i] = DATA_W'($urandom);
    for (int i = 0; i < 256; i++) mem[i] = DATA_W'(i);

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    check_output("reset_tied_write", m_write, 0);
    check_output("reset_tied_clken", m_clken, 1);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] base 0, length 8, ready held high");
    apply_stimulus(0, 8);
    wait_done(1'b0);
    compare_scan("seq8", 0, 8);
    check_output("seq8_cksum_const", cksum, CKSUM_EN ? 28 : 0);

    $display("[TB] scan across the memory end");
    apply_stimulus(MEM_WORDS - 2, 4);
    wait_done(1'b1);
    compare_scan("wrap", MEM_WORDS - 2, 4);

    $display("[TB] consumer stalled for 20 cycles");
    b = $urandom_range(0, MEM_WORDS - 1);
    pix_ready = 1'b0;
    apply_stimulus(b, 16);
    stall_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (pix_valid && pix_data !== mem[b]) stall_bad++;
    end
    check_output("stall_reads", addr_log.size(), FIFO_DEPTH);
    check_output("stall_valid", pix_valid, 1);
    check_output("stall_pix_stable", stall_bad, 0);
    check_output("stall_pix_head", pix_data, mem[b]);
    check_output("stall_no_xfer", pix_log.size(), 0);
    wait_done(1'b0);
    compare_scan("stall", b, 16);

    $display("[TB] zero-length scan");
    apply_stimulus($urandom_range(0, MEM_WORDS - 1), 0);
    check_output("len0_busy_c1", busy, 1);
    check_output("len0_done_c1", done, 0);
    @(negedge clk);
    check_output("len0_busy_c2", busy, 1);
    check_output("len0_done_c2", done, 0);
    @(negedge clk);
    check_output("len0_busy_c3", busy, 0);
    check_output("len0_done_c3", done, 1);
    @(negedge clk);
    check_output("len0_done_c4", done, 0);
    check_output("len0_no_reads", addr_log.size(), 0);
    check_output("len0_done_once", done_cnt, 1);

    $display("[TB] random scans");
    for (int k = 0; k < 5; k++) begin
      b = (k == 0) ? MEM_WORDS - int'($urandom_range(1, 10))
                   : int'($urandom_range(0, MEM_WORDS - 1));
      l = $urandom_range(1, 30);
      apply_stimulus(b, l);
      wait_done(1'b1);
      compare_scan($sformatf("rand%0d", k), b, l);
    end

    $display("[TB] abort on the third read");
    pix_ready = 1'b1;
    apply_stimulus($urandom_range(0, MEM_WORDS - 1), 10);
    reads = 0;
    cyc   = 0;
    while (reads < 3 && cyc < 50) begin
      if (m_chipselect) reads++;
      if (reads < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    check_output("abort_third_read", reads, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_idle", busy, 0);
    check_output("abort_valid", pix_valid, 0);
    check_output("abort_cs", m_chipselect, 0);
    repeat (5) @(negedge clk);
    check_output("abort_no_done", done_cnt, 0);
    check_output("abort_still_empty", pix_valid, 0);
    b = $urandom_range(0, MEM_WORDS - 1);
    apply_stimulus(b, 10);
    wait_done(1'b1);
    compare_scan("post_abort", b, 10);

    $display("[TB] reset in the middle of a scan");
    apply_stimulus($urandom_range(0, MEM_WORDS - 1), 20);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_mid_no_done", done_cnt, 0);
    check_output("rst_mid_idle", busy, 0);
    b = $urandom_range(0, MEM_WORDS - 1);
    apply_stimulus(b, 12);
    repeat (2) @(negedge clk);
    base_addr = ADDR_W'((b + 1000) % MEM_WORDS);
    length    = ADDR_W'(5);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("busy_start_busy", busy, 1);
    wait_done(1'b0);
    compare_scan("busy_start", b, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
